// File: rtl/seq_mem_summer.sv
// Calyx go/done leaf: sums len words from a one-cycle-latency sequential memory.
// Result lands on out; done pulses for one cycle, n+2 cycles after start (1 when n=0).
module seq_mem_summer #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int SIZE       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  output logic                  done,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic                  content_en,
  input  logic [WIDTH-1:0]      read_data,
  output logic [WIDTH-1:0]      out
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH+1)'(SIZE);
  localparam logic [ADDR_WIDTH:0] ONE    = (ADDR_WIDTH+1)'(1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   idx, idx_nxt;
  logic [ADDR_WIDTH:0]   n, n_nxt;
  logic [WIDTH-1:0]      acc, acc_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      n     <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      n     <= n_nxt;
      acc   <= acc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    n_nxt      = n;
    acc_nxt    = acc;
    done       = 1'b0;
    content_en = 1'b0;
    addr0      = '0;
    case (state)
      S_IDLE: begin
        if (go) begin
          n_nxt     = (len > SIZE_W) ? SIZE_W : len;
          acc_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = (n_nxt == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        content_en = 1'b1;
        addr0      = idx[ADDR_WIDTH-1:0];
        // read_data belongs to the address issued in the previous cycle
        if (idx != '0) acc_nxt = acc + read_data;
        idx_nxt = idx + ONE;
        if (idx == n - ONE) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        acc_nxt   = acc + read_data;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign out = acc;

endmodule

// File: doc/seq_mem_summer.md
# seq_mem_summer

Synthesizable Calyx-convention component that sits on the callee side of the go/done handshake, the same interface a top-level test bench drives on `main`. When `go` is seen in idle, it reads `len` words from an attached sequential memory, one-cycle read latency, over a pipelined read port. It accumulates the words modulo 2^WIDTH, pulses `done` for one cycle and holds the sum on `out` until the next run. It serves as a reusable leaf for invoke/handshake regression and as a bench-drivable `main` body.

## Interface
- WIDTH, 32, data and sum width
- ADDR_WIDTH, 4, memory address width
- SIZE, 16, memory depth in words; `len` is clamped to this value
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset (fixed)
- go  in  1  start request, Calyx go
- done  out  1  single-cycle completion pulse, Calyx done
- len  in  ADDR_WIDTH+1  word count, sampled only on the start edge
- addr0  out  ADDR_WIDTH  memory read address
- content_en  out  1  memory read enable; data returns on `read_data` one cycle later
- read_data  in  WIDTH  memory read data
- out  out  WIDTH  accumulated sum, registered

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - done=0, content_en=0, addr0=0; `out` holds its last value.
  - On go=1 at an edge: latch n=min(len,SIZE) and clear the accumulator.
  - If n=0, go to DONE. Otherwise go to FETCH with idx=0.
- FETCH:
  - Each cycle: content_en=1, addr0=idx.
  - From the second FETCH cycle on, add `read_data` (for address idx-1) to the accumulator.
  - idx increments. After the cycle issuing address n-1, go to DRAIN.
- DRAIN: content_en=0; add the last `read_data`; go to DONE.
- DONE:
  - done=1 for exactly this cycle; `out` equals the final sum during this cycle.
  - Always return to IDLE.
- Arithmetic: sum is truncated to WIDTH bits (wraps), with no overflow flag. idx and n are ADDR_WIDTH+1 bits wide.
- `go` is sampled only in IDLE. Deasserting it mid-run is ignored and the run completes.
- If `go` is still high in the IDLE cycle after DONE, a new run starts. The caller must drop `go` on seeing `done` to avoid a restart.
- `len` changes after the start edge have no effect.

## Timing
- Reset values, applied asynchronously on the reset assertion:
  - state=IDLE, done=0, content_en=0, addr0=0, out=0.
  - Accumulator, idx and n are all 0.
- Reset mid-run aborts immediately: no `done` pulse and `out` is cleared. The first edge after deassertion is treated as IDLE.
- Latency, counting edge E0 as the edge where `go` is sampled in IDLE:
  - n≥1: FETCH in cycles 1..n, DRAIN in cycle n+1, done high in cycle n+2.
  - n=0: done high in cycle 1.
- Throughput with `go` held high: one `done` pulse every n+3 cycles (every 2 cycles when n=0).
- Read port: one read issued per FETCH cycle, with no stall input. The memory must return data exactly one cycle after content_en=1.
- `out` updates only as the accumulator register changes. It is stable from DONE until the next start edge.

## Test plan
- len=4, mem={1,2,3,4}, go raised at E0 and dropped when done is seen:
  - content_en high in cycles 1–4 with addr0=0,1,2,3.
  - done high in cycle 6 only, out=10, then IDLE.
- len=0, go pulsed: done high in cycle 1, out=0, and content_en never asserted.
- WIDTH=8, len=2, mem={200,100}: out=44 (wrap), done in cycle 4.
- Reset asserted during the 3rd FETCH cycle of a len=8 run:
  - done, content_en, addr0 and out go to 0 immediately, without waiting for an edge.
  - A subsequent len=3 run over {5,6,7} gives out=18 and done in cycle 5.
- go held high with len=2, mem={3,4}: done pulses in cycles 4, 9 and 14, out=7 each time, with no missed or extra pulses.
- len=20 with SIZE=16, mem[i]=1:
  - Clamped to 16 reads; addr0 never exceeds 15.
  - out=16 and done in cycle 18.
